// File: rtl/power_rail_sequencer_if.sv
// Request/status bundle between the rail sequencer (slave) and its requesters,
// the rail regulators and the ARM shutdown handshake (master).
interface power_rail_sequencer_if #(
   parameter int N_RAILS = 4
);
   logic               pwr_on_req;
   logic               key_powdn_req;
   logic               ARM_powdn_cmd;
   logic               ARM_shutdown_ack;
   logic               arm_heartbeat;
   logic               fault_clr;
   logic [N_RAILS-1:0] rail_pg;
   logic [N_RAILS-1:0] rail_en;
   logic               powen_sys;
   logic               arm_shutdown_req;
   logic               fault;
   logic [N_RAILS-1:0] fault_rail;
   logic [2:0]         seq_state;

   modport master (
      output pwr_on_req, key_powdn_req, ARM_powdn_cmd, ARM_shutdown_ack,
             arm_heartbeat, fault_clr, rail_pg,
      input  rail_en, powen_sys, arm_shutdown_req, fault, fault_rail, seq_state
   );

   modport slave (
      input  pwr_on_req, key_powdn_req, ARM_powdn_cmd, ARM_shutdown_ack,
             arm_heartbeat, fault_clr, rail_pg,
      output rail_en, powen_sys, arm_shutdown_req, fault, fault_rail, seq_state
   );
endinterface

// File: rtl/power_rail_sequencer.sv
// Power rail sequencer: ordered rail enable/disable, power-good supervision and ARM shutdown
// handshake. Define PSEQ_WDOG_EN to add the ARM heartbeat watchdog while ON.
module power_rail_sequencer #(
   parameter int TICK_DIV    = 80000,
   parameter int N_RAILS     = 4,
   parameter int PG_TIMEOUT  = 50,
   parameter int ON_GAP      = 10,
   parameter int OFF_GAP     = 5,
   parameter int ACK_TIMEOUT = 2000,
   parameter int WDOG_TICKS  = 3000
) (
   input logic                   clk_sys,
   input logic                   RESET,
   power_rail_sequencer_if.slave bus
);
   localparam int IW   = (N_RAILS > 1) ? $clog2(N_RAILS) : 1;
   localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int M1   = (PG_TIMEOUT > ON_GAP) ? PG_TIMEOUT : ON_GAP;
   localparam int M2   = (OFF_GAP > ACK_TIMEOUT) ? OFF_GAP : ACK_TIMEOUT;
   localparam int CMAX = (M1 > M2) ? M1 : M2;
   localparam int CW   = $clog2(CMAX + 2);
   localparam logic [N_RAILS-1:0] ONE_N = {{(N_RAILS-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      ST_OFF       = 3'd0,
      ST_RAMP_UP   = 3'd1,
      ST_ON        = 3'd2,
      ST_NOTIFY    = 3'd3,
      ST_RAMP_DOWN = 3'd4,
      ST_FAULT     = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [IW-1:0]      idx_q, idx_d, hi_idx_s;
   logic [PW-1:0]      presc_q, presc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               gap_q, gap_d;
   logic [N_RAILS-1:0] rail_en_q, rail_en_d, fault_rail_q, fault_rail_d;
   logic               powen_q, powen_d, req_q, req_d, fault_q, fault_d;
   logic [N_RAILS-1:0] pg_meta_q, pg_sync_q, pg_low_s;
   logic               tick_s, pg_to_s, wdog_exp_s;

   assign tick_s   = (presc_q == PW'(TICK_DIV - 1));
   assign pg_low_s = rail_en_q & ~pg_sync_q;
   assign pg_to_s  = !gap_q && !pg_sync_q[idx_q] && (cnt_q >= CW'(PG_TIMEOUT));

`ifdef PSEQ_WDOG_EN
   localparam int WW = $clog2(WDOG_TICKS + 2);
   logic [2:0]    hb_q, hb_d;
   logic [WW-1:0] wdog_q, wdog_d;

   // Heartbeat edge detect and watchdog window; the window only runs while ON.
   always_comb begin
      hb_d = {hb_q[1:0], bus.arm_heartbeat};
      if ((state_q != ST_ON) || (hb_q[2] ^ hb_q[1])) wdog_d = '0;
      else if (tick_s && (wdog_q != '1))             wdog_d = wdog_q + WW'(1);
      else                                           wdog_d = wdog_q;
   end

   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         hb_q   <= '0;
         wdog_q <= '0;
      end else begin
         hb_q   <= hb_d;
         wdog_q <= wdog_d;
      end
   end

   assign wdog_exp_s = (state_q == ST_ON) && (wdog_q >= WW'(WDOG_TICKS));
`else
   logic unused_hb_s;
   assign unused_hb_s = bus.arm_heartbeat;
   assign wdog_exp_s  = 1'b0;
`endif

   // Highest enabled rail: where a power-down starts.
   always_comb begin
      hi_idx_s = '0;
      for (int i = 0; i < N_RAILS; i++) begin
         if (rail_en_q[i]) hi_idx_s = IW'(i);
         else              hi_idx_s = hi_idx_s;
      end
   end

   // Next state, rail index and rail enables.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      gap_d        = gap_q;
      rail_en_d    = rail_en_q;
      fault_d      = fault_q;
      fault_rail_d = fault_rail_q;
      case (state_q)
         ST_OFF: begin
            if (bus.pwr_on_req) begin
               state_d   = ST_RAMP_UP;
               idx_d     = '0;
               rail_en_d = ONE_N;
            end else if (bus.fault_clr) begin
               fault_d      = 1'b0;
               fault_rail_d = '0;
            end else begin
               state_d = ST_OFF;
            end
         end
         ST_RAMP_UP: begin
            if (pg_to_s) begin
               state_d      = ST_FAULT;
               fault_d      = 1'b1;
               fault_rail_d = ONE_N << idx_q;
               rail_en_d    = '0;
            end else if (bus.ARM_powdn_cmd || bus.key_powdn_req) begin
               state_d             = ST_RAMP_DOWN;
               idx_d               = hi_idx_s;
               rail_en_d[hi_idx_s] = 1'b0;
            end else if (!gap_q) begin
               // The last rail goes straight to ON without an inter-rail gap.
               if (pg_sync_q[idx_q] && (idx_q == IW'(N_RAILS - 1))) state_d = ST_ON;
               else if (pg_sync_q[idx_q])                           gap_d   = 1'b1;
               else                                                 gap_d   = 1'b0;
            end else if (cnt_q >= CW'(ON_GAP)) begin
               idx_d                        = idx_q + IW'(1);
               gap_d                        = 1'b0;
               rail_en_d[idx_q + IW'(1)]    = 1'b1;
            end else begin
               state_d = ST_RAMP_UP;
            end
         end
         ST_ON: begin
            if (|pg_low_s) begin
               state_d      = ST_FAULT;
               fault_d      = 1'b1;
               fault_rail_d = pg_low_s & (~pg_low_s + ONE_N);
               rail_en_d    = '0;
            end else if (bus.ARM_powdn_cmd) begin
               state_d             = ST_RAMP_DOWN;
               idx_d               = hi_idx_s;
               rail_en_d[hi_idx_s] = 1'b0;
            end else if (bus.key_powdn_req) begin
               state_d = ST_NOTIFY;
            end else if (wdog_exp_s) begin
               state_d             = ST_RAMP_DOWN;
               idx_d               = hi_idx_s;
               rail_en_d[hi_idx_s] = 1'b0;
               fault_d             = 1'b1;
               fault_rail_d        = '0;
            end else begin
               state_d = ST_ON;
            end
         end
         ST_NOTIFY: begin
            if (bus.ARM_powdn_cmd || bus.ARM_shutdown_ack || (cnt_q >= CW'(ACK_TIMEOUT))) begin
               state_d             = ST_RAMP_DOWN;
               idx_d               = hi_idx_s;
               rail_en_d[hi_idx_s] = 1'b0;
            end else begin
               state_d = ST_NOTIFY;
            end
         end
         ST_RAMP_DOWN: begin
            if ((cnt_q >= CW'(OFF_GAP)) && (idx_q == '0)) begin
               state_d = ST_OFF;
            end else if (cnt_q >= CW'(OFF_GAP)) begin
               idx_d                     = idx_q - IW'(1);
               rail_en_d[idx_q - IW'(1)] = 1'b0;
            end else begin
               state_d = ST_RAMP_DOWN;
            end
         end
         ST_FAULT: begin
            rail_en_d = '0;
            if (bus.fault_clr) begin
               state_d      = ST_OFF;
               fault_d      = 1'b0;
               fault_rail_d = '0;
            end else begin
               state_d = ST_FAULT;
            end
         end
         default: begin
            state_d   = ST_OFF;
            idx_d     = '0;
            rail_en_d = '0;
         end
      endcase
      gap_d = (state_d == ST_RAMP_UP) ? gap_d : 1'b0;
   end

   // Prescaler, saturating phase counter (restarted on any phase change) and output flags.
   always_comb begin
      presc_d = tick_s ? '0 : presc_q + PW'(1);
      if ((state_d != state_q) || (idx_d != idx_q) || (gap_d != gap_q)) cnt_d = '0;
      else if (tick_s && (cnt_q != '1))                                 cnt_d = cnt_q + CW'(1);
      else                                                              cnt_d = cnt_q;
      powen_d = (state_d == ST_ON) || (state_d == ST_NOTIFY);
      req_d   = (state_d == ST_NOTIFY);
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         state_q      <= ST_OFF;
         idx_q        <= '0;
         presc_q      <= '0;
         cnt_q        <= '0;
         gap_q        <= 1'b0;
         rail_en_q    <= '0;
         fault_rail_q <= '0;
         powen_q      <= 1'b0;
         req_q        <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         presc_q      <= presc_d;
         cnt_q        <= cnt_d;
         gap_q        <= gap_d;
         rail_en_q    <= rail_en_d;
         fault_rail_q <= fault_rail_d;
         powen_q      <= powen_d;
         req_q        <= req_d;
         fault_q      <= fault_d;
      end
   end

   // Two-stage synchroniser for the asynchronous power-good inputs.
   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         pg_meta_q <= '0;
         pg_sync_q <= '0;
      end else begin
         pg_meta_q <= bus.rail_pg;
         pg_sync_q <= pg_meta_q;
      end
   end

   assign bus.rail_en          = rail_en_q;
   assign bus.powen_sys        = powen_q;
   assign bus.arm_shutdown_req = req_q;
   assign bus.fault            = fault_q;
   assign bus.fault_rail       = fault_rail_q;
   assign bus.seq_state        = state_q;
endmodule

// File: tb/tb_power_rail_sequencer.sv
// Self-checking bench for power_rail_sequencer: randomized scenarios checked against
// sequencing rules (rail order, tick-exact gaps and timeouts, fault reporting).
module tb_power_rail_sequencer;
   localparam int TICK_DIV    = 10;
   localparam int N_RAILS     = 4;
   localparam int PG_TIMEOUT  = 5;
   localparam int ON_GAP      = 2;
   localparam int OFF_GAP     = 3;
   localparam int ACK_TIMEOUT = 20;
   localparam int S_OFF = 0, S_UP = 1, S_ON = 2, S_NOTIFY = 3, S_DOWN = 4, S_FAULT = 5;
   localparam int ALL_ON = (1 << N_RAILS) - 1;

   logic        clk = 1'b0;
   logic        rst;
   int          n_cmp = 0;
   int          n_err = 0;
   int unsigned ecnt  = 0;

   power_rail_sequencer_if #(.N_RAILS(N_RAILS)) bus ();

   power_rail_sequencer #(
      .TICK_DIV(TICK_DIV), .N_RAILS(N_RAILS), .PG_TIMEOUT(PG_TIMEOUT), .ON_GAP(ON_GAP),
      .OFF_GAP(OFF_GAP), .ACK_TIMEOUT(ACK_TIMEOUT), .WDOG_TICKS(3000)
   ) dut (
      .clk_sys(clk),
      .RESET  (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
      end
   endtask

   // One clock: returns at the falling edge after the next rising edge.
   task automatic cyc();
      @(negedge clk);
      ecnt++;
   endtask

   // The prescaler restarts with reset, so the k-th edge after release is a tick when k % TICK_DIV == 0.
   function automatic bit is_tick();
      return (ecnt != 0) && (ecnt % TICK_DIV == 0);
   endfunction

   function automatic int top_cleared(input int m);
      for (int i = N_RAILS - 1; i >= 0; i--)
         if (m[i]) return m & ~(1 << i);
      return m;
   endfunction

   function automatic int lowest(input int m);
      for (int i = 0; i < N_RAILS; i++)
         if (m[i]) return 1 << i;
      return 0;
   endfunction

   task automatic chk_out(input string tag, input int st, input int en);
      check({tag, "_state"}, 32'(bus.seq_state), st);
      check({tag, "_rail_en"}, 32'(bus.rail_en), en);
   endtask

   // Waits for rail_en or seq_state to change; ticks = tick edges seen before the changing edge.
   task automatic wait_change(input string tag, input int max_cyc, output int ticks);
      logic [N_RAILS-1:0] e0;
      logic [2:0]         s0;
      bit                 done;
      e0    = bus.rail_en;
      s0    = bus.seq_state;
      ticks = 0;
      done  = 1'b0;
      for (int n = 0; n < max_cyc && !done; n++) begin
         cyc();
         if (bus.rail_en !== e0 || bus.seq_state !== s0) done = 1'b1;
         else if (is_tick()) ticks++;
      end
      check({tag, "_progress"}, 32'(done), 1);
   endtask

   task automatic wait_ticks(input int n);
      int c = 0;
      while (c < n) begin
         cyc();
         if (is_tick()) c++;
      end
   endtask

   task automatic start_up();
      int t;
      bus.pwr_on_req = 1'b1;
      wait_change("start", 4, t);
      chk_out("start", S_UP, 1);
      bus.pwr_on_req = 1'b0;
   endtask

   // rail i has just been enabled: supply its power-good after a random delay below the timeout.
   task automatic up_rail(input int i);
      int d, t;
      d = $urandom_range(1, PG_TIMEOUT - 1);
      wait_ticks(d);
      bus.rail_pg[i] = 1'b1;
      wait_change("gap", (ON_GAP + 2) * TICK_DIV, t);
      if (i < N_RAILS - 1) begin
         check("on_gap_ticks", t, ON_GAP);
         chk_out("up_step", S_UP, (1 << (i + 2)) - 1);
      end else begin
         check("on_entry_ticks", t, 0);
         chk_out("on", S_ON, ALL_ON);
         check("on_powen", 32'(bus.powen_sys), 1);
         check("on_req", 32'(bus.arm_shutdown_req), 0);
      end
   endtask

   task automatic full_up();
      start_up();
      for (int i = 0; i < N_RAILS; i++) up_rail(i);
   endtask

   // Entry into RAMP_DOWN already observed with rails 'cur' still enabled.
   task automatic ramp_down(input int cur);
      int t;
      check("down_powen", 32'(bus.powen_sys), 0);
      check("down_req", 32'(bus.arm_shutdown_req), 0);
      while (cur != 0) begin
         wait_change("down", (OFF_GAP + 2) * TICK_DIV, t);
         check("off_gap_ticks", t, OFF_GAP);
         cur = top_cleared(cur);
         chk_out("down_step", S_DOWN, cur);
      end
      wait_change("off", (OFF_GAP + 2) * TICK_DIV, t);
      check("off_gap_last", t, OFF_GAP);
      chk_out("off", S_OFF, 0);
   endtask

   task automatic arm_cmd_shutdown();
      bus.ARM_powdn_cmd = 1'b1;
      cyc();
      bus.ARM_powdn_cmd = 1'b0;
      chk_out("cmd_down", S_DOWN, top_cleared(ALL_ON));
      bus.rail_pg = '0;
      ramp_down(top_cleared(ALL_ON));
   endtask

   // ack_ticks == 0 means the ARM never acknowledges.
   task automatic key_shutdown(input int ack_ticks, input bit hold);
      int t;
      bus.pwr_on_req    = hold;
      bus.key_powdn_req = 1'b1;
      cyc();
      bus.key_powdn_req = 1'b0;
      chk_out("notify", S_NOTIFY, ALL_ON);
      check("notify_req", 32'(bus.arm_shutdown_req), 1);
      check("notify_powen", 32'(bus.powen_sys), 1);
      if (ack_ticks > 0) begin
         wait_ticks(ack_ticks);
         bus.ARM_shutdown_ack = 1'b1;
      end
      wait_change("notify", (ACK_TIMEOUT + 2) * TICK_DIV, t);
      check("notify_ticks", ack_ticks + t, (ack_ticks > 0) ? ack_ticks : ACK_TIMEOUT);
      chk_out("key_down", S_DOWN, top_cleared(ALL_ON));
      bus.ARM_shutdown_ack = 1'b0;
      bus.rail_pg          = '0;
      ramp_down(top_cleared(ALL_ON));
   endtask

   task automatic pg_timeout(input int r);
      int t;
      start_up();
      bus.pwr_on_req = 1'b1;
      for (int i = 0; i < r; i++) up_rail(i);
      wait_change("pgto", (PG_TIMEOUT + 2) * TICK_DIV, t);
      check("pgto_ticks", t, PG_TIMEOUT);
      chk_out("pgto", S_FAULT, 0);
      check("pgto_fault", 32'(bus.fault), 1);
      check("pgto_rail", 32'(bus.fault_rail), 1 << r);
      check("pgto_powen", 32'(bus.powen_sys), 0);
      repeat (5) cyc();
      check("fault_holds", 32'(bus.seq_state), S_FAULT);
      clear_fault();
   endtask

   task automatic clear_fault();
      bus.pwr_on_req = 1'b0;
      bus.rail_pg    = '0;
      bus.fault_clr  = 1'b1;
      cyc();
      bus.fault_clr  = 1'b0;
      chk_out("clr", S_OFF, 0);
      check("clr_fault", 32'(bus.fault), 0);
      check("clr_rail", 32'(bus.fault_rail), 0);
   endtask

   task automatic abort_up(input int k, input bit use_key);
      int m;
      start_up();
      for (int i = 0; i < k; i++) up_rail(i);
      m = (1 << (k + 1)) - 1;
      if (use_key) bus.key_powdn_req = 1'b1;
      else         bus.ARM_powdn_cmd = 1'b1;
      cyc();
      bus.key_powdn_req = 1'b0;
      bus.ARM_powdn_cmd = 1'b0;
      chk_out("abort", S_DOWN, top_cleared(m));
      bus.rail_pg = '0;
      ramp_down(top_cleared(m));
   endtask

   task automatic on_fault(input int m, input bit with_cmd);
      logic [N_RAILS-1:0] mv;
      full_up();
      mv          = N_RAILS'(m);
      bus.rail_pg = bus.rail_pg & ~mv;
      cyc();
      cyc();
      check("pgdrop_sync", 32'(bus.seq_state), S_ON);
      if (with_cmd) bus.ARM_powdn_cmd = 1'b1;
      cyc();
      bus.ARM_powdn_cmd = 1'b0;
      chk_out("onfault", S_FAULT, 0);
      check("onfault_rail", 32'(bus.fault_rail), lowest(m));
      check("onfault_powen", 32'(bus.powen_sys), 0);
      clear_fault();
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int sc, t;
      rst                  = 1'b1;
      bus.pwr_on_req       = 1'b0;
      bus.key_powdn_req    = 1'b0;
      bus.ARM_powdn_cmd    = 1'b0;
      bus.ARM_shutdown_ack = 1'b0;
      bus.arm_heartbeat    = 1'b0;
      bus.fault_clr        = 1'b0;
      bus.rail_pg          = '0;
      repeat (2) @(negedge clk);
      chk_out("reset", S_OFF, 0);
      check("reset_powen", 32'(bus.powen_sys), 0);
      check("reset_fault", 32'(bus.fault), 0);
      rst  = 1'b0;
      ecnt = 0;

      bus.key_powdn_req = 1'b1;
      cyc();
      bus.key_powdn_req = 1'b0;
      check("key_in_off", 32'(bus.seq_state), S_OFF);
      cyc();
      check("key_not_latched", 32'(bus.seq_state), S_OFF);

      for (int it = 0; it < 10; it++) begin
         sc = (it < 6) ? it : int'($urandom_range(0, 5));
         case (sc)
            0: begin
               full_up();
               key_shutdown($urandom_range(1, 15), 1'b0);
            end
            1: begin
               full_up();
               key_shutdown(0, 1'b1);
               wait_change("restart", 4, t);
               chk_out("restart", S_UP, 1);
               bus.pwr_on_req = 1'b0;
               for (int i = 0; i < N_RAILS; i++) up_rail(i);
               arm_cmd_shutdown();
            end
            2: begin
               full_up();
               arm_cmd_shutdown();
            end
            3: pg_timeout($urandom_range(0, N_RAILS - 1));
            4: abort_up($urandom_range(0, N_RAILS - 2), 1'($urandom_range(0, 1)));
            default: on_fault($urandom_range(1, ALL_ON), 1'($urandom_range(0, 1)));
         endcase
      end
      on_fault(4, 1'b1);

      full_up();
      bus.ARM_powdn_cmd = 1'b1;
      cyc();
      bus.ARM_powdn_cmd = 1'b0;
      bus.rail_pg       = '0;
      cyc();
      check("pre_reset_state", 32'(bus.seq_state), S_DOWN);
      #2 rst = 1'b1;
      #1;
      chk_out("async_reset", S_OFF, 0);
      check("async_reset_powen", 32'(bus.powen_sys), 0);
      @(negedge clk);
      rst  = 1'b0;
      ecnt = 0;
      repeat (2) cyc();
      check("after_reset", 32'(bus.seq_state), S_OFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
